// File: rtl/tdc_pkg.sv
// Shared TDC result types: field widths and the packed buffer entry.
package tdc_pkg;

   localparam int TDC_DATA_W = 28;
   localparam int TDC_ADDR_W = 4;
   localparam int TDC_SEQ_W  = 8;

   typedef struct packed {
      logic [TDC_SEQ_W-1:0]  seq;
      logic [TDC_ADDR_W-1:0] addr;
      logic [TDC_DATA_W-1:0] data;
   } tdc_entry_t;

   localparam int TDC_ENTRY_W = $bits(tdc_entry_t);

endpackage

// File: rtl/tdc_sync_fifo.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers and occupancy.
// level_next exposes the post-edge occupancy so callers can register flags without lag.
module tdc_sync_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     level,
   output logic [$clog2(DEPTH):0]     level_next,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // DEPTH is a power of two, so pointer increments wrap naturally
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata      = mem_q[rd_ptr_q];
   assign level      = level_q;
   assign level_next = level_d;
   assign full       = (level_q == DEPTH_L);
   assign empty      = (level_q == '0);

endmodule

// File: rtl/tdc_result_buffer.sv
// Tags TDC results with a sequence number, buffers them and throttles the sequencer.
// Optional statistics (drop_cnt, max_lvl) are enabled by defining TDC_BUF_STAT_EN.
module tdc_result_buffer
   import tdc_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       res_valid,
   input  logic [TDC_DATA_W-1:0]      res_data,
   input  logic [TDC_ADDR_W-1:0]      res_addr,
   output logic                       rd_enable,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [TDC_DATA_W-1:0]      out_data,
   output logic [TDC_ADDR_W-1:0]      out_addr,
   output logic [TDC_SEQ_W-1:0]       out_seq,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf,
   input  logic                       ovf_clr,
   input  logic                       flush
`ifdef TDC_BUF_STAT_EN
   ,
   output logic [15:0]                drop_cnt,
   output logic [$clog2(DEPTH):0]     max_lvl
`endif
);

   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] AFULL_L = LVL_W'(AFULL_LVL);

   tdc_entry_t            wr_entry, head;
   logic [LVL_W-1:0]      level_next;
   logic                  full, empty;
   logic                  push, pop, drop;
   logic [TDC_SEQ_W-1:0]  seq_q, seq_d;
   logic                  ovf_q, ovf_d;
   logic                  rd_enable_q, rd_enable_d;

   tdc_sync_fifo #(
      .WIDTH (TDC_ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .wdata      (wr_entry),
      .rdata      (head),
      .level      (level),
      .level_next (level_next),
      .full       (full),
      .empty      (empty)
   );

   always_comb begin
      // Flush discards both the pop and any push arriving in the same cycle
      pop           = !empty && out_ready && !flush;
      push          = res_valid && (!full || pop) && !flush;
      drop          = res_valid && full && !pop && !flush;
      wr_entry.seq  = seq_q;
      wr_entry.addr = res_addr;
      wr_entry.data = res_data;
      seq_d         = seq_q + TDC_SEQ_W'(push);
      ovf_d         = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
      rd_enable_d   = (level_next < AFULL_L);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seq_q       <= '0;
         ovf_q       <= 1'b0;
         rd_enable_q <= 1'b1;
      end else begin
         seq_q       <= seq_d;
         ovf_q       <= ovf_d;
         rd_enable_q <= rd_enable_d;
      end
   end

   // Head fields read as zero while empty so reset leaves clean outputs
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : head.data;
   assign out_addr  = empty ? '0 : head.addr;
   assign out_seq   = empty ? '0 : head.seq;
   assign ovf       = ovf_q;
   assign rd_enable = rd_enable_q;

`ifdef TDC_BUF_STAT_EN
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [LVL_W-1:0] max_lvl_q, max_lvl_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (ovf_clr)
         drop_cnt_d = drop ? 16'd1 : 16'd0;
      else if (drop && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
      max_lvl_d = max_lvl_q;
      if (flush)
         max_lvl_d = '0;
      else if (level_next > max_lvl_q)
         max_lvl_d = level_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
         max_lvl_q  <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         max_lvl_q  <= max_lvl_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign max_lvl  = max_lvl_q;
`endif

endmodule

// File: tb/tb_tdc_result_buffer.sv
// Directed bench for tdc_result_buffer; statistics checks compile in with TDC_BUF_STAT_EN.
module tb_tdc_result_buffer;
   import tdc_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset, res_valid, out_ready, ovf_clr, flush;
   logic [TDC_DATA_W-1:0] res_data;
   logic [TDC_ADDR_W-1:0] res_addr;
   logic                  rd_enable, out_valid, ovf;
   logic [TDC_DATA_W-1:0] out_data;
   logic [TDC_ADDR_W-1:0] out_addr;
   logic [TDC_SEQ_W-1:0]  out_seq;
   logic [4:0]            level;
`ifdef TDC_BUF_STAT_EN
   logic [15:0]           drop_cnt;
   logic [4:0]            max_lvl;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tdc_result_buffer #(.DEPTH(16), .AFULL_LVL(12)) dut (
      .clk       (clk),
      .reset     (reset),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_addr  (res_addr),
      .rd_enable (rd_enable),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_seq   (out_seq),
      .level     (level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .flush     (flush)
`ifdef TDC_BUF_STAT_EN
      ,
      .drop_cnt  (drop_cnt),
      .max_lvl   (max_lvl)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_level"}, 64'(level), 64'd0);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_rden"},  64'(rd_enable), 64'd1);
      chk({tag, "_ovf"},   64'(ovf), 64'd0);
      chk({tag, "_data"},  64'(out_data), 64'd0);
      chk({tag, "_seq"},   64'(out_seq), 64'd0);
`ifdef TDC_BUF_STAT_EN
      chk({tag, "_dropcnt"}, 64'(drop_cnt), 64'd0);
      chk({tag, "_maxlvl"},  64'(max_lvl), 64'd0);
`endif
   endtask

   initial begin
      reset = 1'b1; res_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; flush = 1'b0;
      res_data = '0; res_addr = '0;
      step(); step();
      reset = 1'b0;
      check_reset_state("rst");

      // 1: single push
      res_valid = 1'b1; res_data = 28'h0ABCDEF; res_addr = 4'h3;
      step();
      res_valid = 1'b0;
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_seq",   64'(out_seq), 64'd0);
      chk("t1_data",  64'(out_data), 64'h0ABCDEF);
      chk("t1_addr",  64'(out_addr), 64'h3);
      chk("t1_level", 64'(level), 64'd1);

      // 2: fill to 16 then overflow
      for (int i = 1; i < 16; i++) begin
         res_valid = 1'b1; res_data = 28'h100 + 28'(i); res_addr = 4'(i);
         step();
         if (i + 1 == 11) chk("t2_rden_l11", 64'(rd_enable), 64'd1);
         if (i + 1 == 12) chk("t2_rden_l12", 64'(rd_enable), 64'd0);
      end
      chk("t2_level16", 64'(level), 64'd16);
      chk("t2_ovf_pre", 64'(ovf), 64'd0);
      res_data = 28'hDEAD; res_addr = 4'hF;
      step();
      res_valid = 1'b0;
      chk("t2_ovf", 64'(ovf), 64'd1);
      chk("t2_level_drop", 64'(level), 64'd16);
      chk("t2_head_seq", 64'(out_seq), 64'd0);

      // 3: clear ovf, then push+pop while full
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", 64'(ovf), 64'd0);
      res_valid = 1'b1; res_data = 28'hBEEF0; res_addr = 4'hA; out_ready = 1'b1;
      step();
      res_valid = 1'b0;
      chk("t3_level", 64'(level), 64'd16);
      chk("t3_ovf",   64'(ovf), 64'd0);
      chk("t3_head",  64'(out_seq), 64'd1);

      // 4: drain; seq 16 (the full-time push) comes out last
      for (int k = 0; k < 16; k++) begin
         chk("t4_seq",  64'(out_seq), 64'(k + 1));
         chk("t4_data", 64'(out_data), (k == 15) ? 64'hBEEF0 : 64'(28'h100 + 28'(k + 1)));
         chk("t4_addr", 64'(out_addr), (k == 15) ? 64'hA : 64'((k + 1) % 16));
         step();
         if (15 - k == 12) chk("t4_rden_l12", 64'(rd_enable), 64'd0);
         if (15 - k == 11) chk("t4_rden_l11", 64'(rd_enable), 64'd1);
      end
      chk("t4_valid_empty", 64'(out_valid), 64'd0);
      chk("t4_level_empty", 64'(level), 64'd0);
      step();
      chk("t4_pop_empty", 64'(level), 64'd0);
      // empty + push + ready: push only
      res_valid = 1'b1; res_data = 28'h55; res_addr = 4'h5;
      step();
      res_valid = 1'b0;
      chk("t4_epush_level", 64'(level), 64'd1);
      chk("t4_epush_seq",   64'(out_seq), 64'd17);
      step();
      out_ready = 1'b0;
      chk("t4_epush_drain", 64'(level), 64'd0);

      // 5: five pushes (seq 18..22), flush with a push, next push seq 23
      for (int i = 0; i < 5; i++) begin
         res_valid = 1'b1; res_data = 28'(i); res_addr = 4'(i);
         step();
      end
      chk("t5_level5", 64'(level), 64'd5);
      flush = 1'b1; res_data = 28'hFFF;
      step();
      flush = 1'b0; res_valid = 1'b0;
      chk("t5_flush_level", 64'(level), 64'd0);
      chk("t5_flush_valid", 64'(out_valid), 64'd0);
      res_valid = 1'b1; res_data = 28'h777; res_addr = 4'h7;
      step();
      res_valid = 1'b0;
      chk("t5_seq_cont", 64'(out_seq), 64'd23);
      chk("t5_data",     64'(out_data), 64'h777);
`ifdef TDC_BUF_STAT_EN
      chk("t6_maxlvl_flush", 64'(max_lvl), 64'd1);
`endif

      // 6: fill, three drops, clears, reset mid-burst
      for (int i = 0; i < 15; i++) begin
         res_valid = 1'b1; res_data = 28'(i); step();
      end
      step(); step(); step();
      res_valid = 1'b0;
      chk("t6_ovf", 64'(ovf), 64'd1);
      chk("t6_level", 64'(level), 64'd16);
`ifdef TDC_BUF_STAT_EN
      chk("t6_dropcnt3", 64'(drop_cnt), 64'd3);
      chk("t6_maxlvl16", 64'(max_lvl), 64'd16);
`endif
      ovf_clr = 1'b1;
      step();
      chk("t6_ovf_cleared", 64'(ovf), 64'd0);
`ifdef TDC_BUF_STAT_EN
      chk("t6_dropcnt_clr", 64'(drop_cnt), 64'd0);
`endif
      res_valid = 1'b1;
      step();
      ovf_clr = 1'b0; res_valid = 1'b0;
      chk("t6_set_wins", 64'(ovf), 64'd1);
`ifdef TDC_BUF_STAT_EN
      chk("t6_dropcnt_one", 64'(drop_cnt), 64'd1);
`endif
      res_valid = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0; res_valid = 1'b0;
      check_reset_state("rst_mid");
      res_valid = 1'b1; res_data = 28'h1234; res_addr = 4'h2;
      step();
      res_valid = 1'b0;
      chk("t6_seq_after_rst", 64'(out_seq), 64'd0);
      chk("t6_data_after_rst", 64'(out_data), 64'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
